lcd_if_driver: RTL and testbench

- Physical-side driver for the HD44780-style 16x2 character LCD.
- Consumes the RW/RS/DATA byte stream emitted by the display-mode blocks (clock, time-set, etc.) and converts each write request into a properly timed LCD_E strobe cycle on the LCD pins.
- Runs the LCD power-on initialisation sequence itself and signals readiness, so producers only pace against READY.
- Sits between the mode-select mux and the top-level LCD pins.

---
 rtl/lcd_if_driver.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd_if_driver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_if_driver.sv
// -----------------------------------------------------------------------------
// lcd_if_driver
//
// Physical-side driver for an HD44780-style 16x2 character LCD. It runs the
// power-on initialisation sequence on its own, then accepts one RS/DATA byte
// per READY window from the display-mode mux and turns it into a timed LCD_E
// strobe cycle on the LCD pins.
//
// Ports:
//   CLK         system clock (same tick that paces the mode blocks)
//   RESET       asynchronous, active-high reset
//   RW_INPUT    0 = write request this cycle, 1 = no request
//   RS_INPUT    0 = instruction, 1 = character data
//   DATA_INPUT  instruction or character code
//   READY       driver accepts a request on the next rising edge
//   INIT_DONE   power-on sequence complete (sticky until reset)
//   LCD_E       LCD enable strobe
//   LCD_RS      LCD register select
//   LCD_RW      LCD read/write, held at 0 (write-only)
//   LCD_DATA    LCD data bus
//   DROP_CNT    (only with LCD_DROP_CNT_EN) saturating count of requests
//               that arrived while READY was low after initialisation
//
// Optional feature macro: LCD_DROP_CNT_EN
//
// Timing (defaults): a byte occupies SETUP, STROBE, WAIT and one IDLE cycle,
// so back-to-back accepts are four edges apart; clear/return-home stretch
// WAIT by one extra cycle. Zero-valued timing parameters behave as 1.
// -----------------------------------------------------------------------------
module lcd_if_driver #(
    parameter int INIT_WAIT     = 20,
    parameter int SETUP_CYCLES  = 1,
    parameter int E_HIGH_CYCLES = 1,
    parameter int CMD_WAIT      = 1,
    parameter int CLEAR_WAIT    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RW_INPUT,
    input  logic       RS_INPUT,
    input  logic [7:0] DATA_INPUT,
    output logic       READY,
    output logic       INIT_DONE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
`ifdef LCD_DROP_CNT_EN
    output logic [7:0] LCD_DATA,
    output logic [7:0] DROP_CNT
`else
    output logic [7:0] LCD_DATA
`endif
);

    // Effective cycle counts: a zero parameter is treated as one cycle.
    localparam int INIT_N  = (INIT_WAIT     < 1) ? 1 : INIT_WAIT;
    localparam int SETUP_N = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
    localparam int EHIGH_N = (E_HIGH_CYCLES < 1) ? 1 : E_HIGH_CYCLES;
    localparam int CMD_N   = (CMD_WAIT      < 1) ? 1 : CMD_WAIT;
    localparam int CLEAR_N = (CLEAR_WAIT    < 1) ? 1 : CLEAR_WAIT;

    // The shared phase counter must hold the largest terminal value.
    localparam int MAX_A = (INIT_N  > SETUP_N) ? INIT_N  : SETUP_N;
    localparam int MAX_B = (EHIGH_N > CMD_N)   ? EHIGH_N : CMD_N;
    localparam int MAX_C = (MAX_A   > MAX_B)   ? MAX_A   : MAX_B;
    localparam int MAX_P = (MAX_C   > CLEAR_N) ? MAX_C   : CLEAR_N;
    localparam int CNT_W = $clog2(MAX_P + 1);

    // PWR exits when the counter reaches INIT_N, so the first init command
    // is loaded exactly INIT_N edges after reset release; the other phases
    // exit on the last cycle of their window (N-1).
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_N);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(EHIGH_N - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_N - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_PWR    = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_IDLE   = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       init_idx_r;
    logic             lcd_e_r;
    logic             lcd_rs_r;
    logic             lcd_rw_r;
    logic [7:0]       lcd_data_r;
    logic             ready_r;
    logic             init_done_r;
    logic [CNT_W-1:0] wait_last_s;

    // Power-on command table, all sent as instructions (RS=0).
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;   // function set: 8-bit, 2 lines, 5x8
            2'd1:    cmd = 8'h0C;   // display on, cursor off
            2'd2:    cmd = 8'h06;   // entry mode: increment, no shift
            2'd3:    cmd = 8'h01;   // clear display
            default: cmd = 8'h38;
        endcase
        return cmd;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) are the slow instructions.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        logic long_wait;
        if (rs == 1'b0 && (data == 8'h01 || data[7:1] == 7'b0000001)) begin
            long_wait = 1'b1;
        end else begin
            long_wait = 1'b0;
        end
        return long_wait;
    endfunction

    // Post-strobe wait length chosen from the byte currently on the bus.
    always_comb begin
        wait_last_s = CMD_LAST;
        if (needs_long_wait(lcd_rs_r, lcd_data_r)) begin
            wait_last_s = CLEAR_LAST;
        end else begin
            wait_last_s = CMD_LAST;
        end
    end

    // Main sequencer: power-up delay, init table, accept/strobe cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_PWR;
            cnt_r       <= CNT_ZERO;
            init_idx_r  <= 2'd0;
            lcd_e_r     <= 1'b0;
            lcd_rs_r    <= 1'b0;
            lcd_rw_r    <= 1'b0;
            lcd_data_r  <= 8'h00;
            ready_r     <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            lcd_rw_r <= 1'b0;
            case (state_r)
                ST_PWR: begin
                    if (cnt_r == INIT_LAST) begin
                        cnt_r      <= CNT_ZERO;
                        init_idx_r <= 2'd0;
                        lcd_rs_r   <= 1'b0;
                        lcd_data_r <= init_cmd(2'd0);
                        state_r    <= ST_SETUP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        lcd_e_r <= 1'b1;
                        state_r <= ST_STROBE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_STROBE: begin
                    if (cnt_r == EHIGH_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        lcd_e_r <= 1'b0;
                        state_r <= ST_WAIT;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_WAIT: begin
                    if (cnt_r == wait_last_s) begin
                        cnt_r <= CNT_ZERO;
                        if (!init_done_r && init_idx_r != 2'd3) begin
                            // Still inside the init table: load the next command.
                            init_idx_r <= init_idx_r + 2'd1;
                            lcd_rs_r   <= 1'b0;
                            lcd_data_r <= init_cmd(init_idx_r + 2'd1);
                            state_r    <= ST_SETUP;
                        end else begin
                            // Last init command or a normal byte finished.
                            init_done_r <= 1'b1;
                            ready_r     <= 1'b1;
                            state_r     <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_IDLE: begin
                    if (ready_r && !RW_INPUT) begin
                        cnt_r      <= CNT_ZERO;
                        lcd_rs_r   <= RS_INPUT;
                        lcd_data_r <= DATA_INPUT;
                        ready_r    <= 1'b0;
                        state_r    <= ST_SETUP;
                    end else begin
                        ready_r <= init_done_r;
                    end
                end

                default: begin
                    state_r    <= ST_PWR;
                    cnt_r      <= CNT_ZERO;
                    init_idx_r <= 2'd0;
                    lcd_e_r    <= 1'b0;
                    ready_r    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LCD_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Count requests refused after init because the driver was busy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drop_cnt_r <= 8'h00;
        end else if (!RW_INPUT && !ready_r && init_done_r && drop_cnt_r != 8'hFF) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign DROP_CNT = drop_cnt_r;
`endif

    assign READY     = ready_r;
    assign INIT_DONE = init_done_r;
    assign LCD_E     = lcd_e_r;
    assign LCD_RS    = lcd_rs_r;
    assign LCD_RW    = lcd_rw_r;
    assign LCD_DATA  = lcd_data_r;

endmodule

// File: tb/tb_lcd_if_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd_if_driver
//
// Scoreboard bench for lcd_if_driver. Stimulus pushes the expected {RS,DATA}
// of every byte that should reach the LCD; a monitor pops one entry per LCD_E
// rising edge and compares. Timing (init trace, READY latency, reset) is
// checked directly in the stimulus process against hand-computed values.
// -----------------------------------------------------------------------------
module tb_lcd_if_driver;

    logic       CLK;
    logic       RESET;
    logic       RW_INPUT;
    logic       RS_INPUT;
    logic [7:0] DATA_INPUT;
    logic       READY;
    logic       INIT_DONE;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
`ifdef LCD_DROP_CNT_EN
    logic [7:0] DROP_CNT;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [8:0] exp_q[$];

    lcd_if_driver dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RW_INPUT   (RW_INPUT),
        .RS_INPUT   (RS_INPUT),
        .DATA_INPUT (DATA_INPUT),
        .READY      (READY),
        .INIT_DONE  (INIT_DONE),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
`ifdef LCD_DROP_CNT_EN
        .LCD_DATA   (LCD_DATA),
        .DROP_CNT   (DROP_CNT)
`else
        .LCD_DATA   (LCD_DATA)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard pop per rising LCD_E.
    initial begin
        logic       e_prev;
        logic [8:0] exp_b;
        e_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                e_prev = 1'b0;
            end else begin
                if (LCD_E) chk("ready_low_while_e", {31'd0, READY}, 32'd0);
                if (LCD_E && !e_prev) begin
                    pulses++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe actual=%0h expected=none", {LCD_RS, LCD_DATA});
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("strobe_byte", {23'd0, LCD_RS, LCD_DATA}, {23'd0, exp_b});
                        chk("lcd_rw_zero", {31'd0, LCD_RW}, 32'd0);
                    end
                end
                e_prev = LCD_E;
            end
        end
    end

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // Caller releases RESET at a negedge; the next posedge is edge 0.
    task automatic check_init_trace();
        logic        e_x;
        logic [7:0]  d_x;
        logic        rdy_x;
        for (int k = 0; k < 36; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            e_x   = (k == 21 || k == 24 || k == 27 || k == 30);
            if (k < 20)      d_x = 8'h00;
            else if (k < 23) d_x = 8'h38;
            else if (k < 26) d_x = 8'h0C;
            else if (k < 29) d_x = 8'h06;
            else             d_x = 8'h01;
            rdy_x = (k >= 33);
            chk($sformatf("init_edge%0d", k),
                {20'd0, LCD_E, LCD_RS, LCD_DATA, INIT_DONE, READY},
                {20'd0, e_x, 1'b0, d_x, rdy_x, rdy_x});
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (READY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1");
        end
    endtask

    // Issue one byte when READY is seen; report cycles until READY returns.
    task automatic send_byte(input logic rs, input logic [7:0] data, output int lat,
                             output logic s_rs, output logic [7:0] s_data,
                             output logic s_e0, output logic s_e1);
        bit ok;
        lat = 0; s_rs = 1'b0; s_data = 8'h00; s_e0 = 1'b0; s_e1 = 1'b0;
        wait_ready(ok);
        if (!ok) return;
        RW_INPUT = 1'b0; RS_INPUT = rs; DATA_INPUT = data;
        exp_q.push_back({rs, data});
        @(posedge CLK);
        #1;
        RW_INPUT = 1'b1; RS_INPUT = 1'b1; DATA_INPUT = 8'h02;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            lat++;
            if (lat == 1) begin s_rs = LCD_RS; s_data = LCD_DATA; s_e0 = LCD_E; end
            if (lat == 2) s_e1 = LCD_E;
            if (READY) break;
        end
    endtask

    initial begin
        int         lat;
        int         p0;
        logic       s_rs, s_e0, s_e1;
        logic [7:0] s_data;
        logic [8:0] lat_tab[6];
        int         lat_exp[6];
        bit         ok;

        RESET = 1'b1; RW_INPUT = 1'b1; RS_INPUT = 1'b1; DATA_INPUT = 8'h02;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {20'd0, LCD_E, LCD_RS, LCD_RW, LCD_DATA, READY},
            32'd0);
        chk("reset_init_done", {31'd0, INIT_DONE}, 32'd0);
`ifdef LCD_DROP_CNT_EN
        chk("reset_drop_cnt", {24'd0, DROP_CNT}, 32'd0);
`endif

        // Power-up sequence
        push_init();
        RESET = 1'b0;
        check_init_trace();

        // Single character 'A'
        send_byte(1'b1, 8'h41, lat, s_rs, s_data, s_e0, s_e1);
        chk("char_rs", {31'd0, s_rs}, 32'd1);
        chk("char_data", {24'd0, s_data}, 32'h41);
        chk("char_e_setup", {31'd0, s_e0}, 32'd0);
        chk("char_e_strobe", {31'd0, s_e1}, 32'd1);
        chk("char_latency", lat, 32'd4);

        // READY latency: long wait only for RS=0 clear/return-home
        lat_tab[0] = {1'b0, 8'h01}; lat_exp[0] = 5;
        lat_tab[1] = {1'b0, 8'h80}; lat_exp[1] = 4;
        lat_tab[2] = {1'b0, 8'h02}; lat_exp[2] = 5;
        lat_tab[3] = {1'b0, 8'h03}; lat_exp[3] = 5;
        lat_tab[4] = {1'b0, 8'h04}; lat_exp[4] = 4;
        lat_tab[5] = {1'b1, 8'h01}; lat_exp[5] = 4;
        for (int i = 0; i < 6; i++) begin
            send_byte(lat_tab[i][8], lat_tab[i][7:0], lat, s_rs, s_data, s_e0, s_e1);
            chk($sformatf("latency_%0h", lat_tab[i]), lat, lat_exp[i]);
        end

        // 34-byte line update
        p0 = pulses;
        send_byte(1'b0, 8'h80, lat, s_rs, s_data, s_e0, s_e1);
        for (int i = 0; i < 16; i++)
            send_byte(1'b1, 8'h41 + 8'(i), lat, s_rs, s_data, s_e0, s_e1);
        send_byte(1'b0, 8'hC0, lat, s_rs, s_data, s_e0, s_e1);
        for (int i = 0; i < 16; i++)
            send_byte(1'b1, 8'h61 + 8'(i), lat, s_rs, s_data, s_e0, s_e1);
        chk("stream_pulses", pulses - p0, 32'd34);

        // Idle pattern produces no LCD activity
        p0 = pulses;
        RW_INPUT = 1'b1; RS_INPUT = 1'b1; DATA_INPUT = 8'h02;
        repeat (10) @(negedge CLK);
        chk("idle_no_pulse", pulses - p0, 32'd0);
        chk("idle_ready", {31'd0, READY}, 32'd1);

        // Three requests during the WAIT of a clear are dropped
        p0 = pulses;
        wait_ready(ok);
        RW_INPUT = 1'b0; RS_INPUT = 1'b0; DATA_INPUT = 8'h01;
        exp_q.push_back({1'b0, 8'h01});
        @(posedge CLK);
        #1;
        RS_INPUT = 1'b1; DATA_INPUT = 8'hAA;
        repeat (3) @(posedge CLK);
        #1;
        RW_INPUT = 1'b1; DATA_INPUT = 8'h02;
        wait_ready(ok);
        repeat (4) @(negedge CLK);
        chk("drop3_pulses", pulses - p0, 32'd1);
`ifdef LCD_DROP_CNT_EN
        chk("drop_cnt_3", {24'd0, DROP_CNT}, 32'd3);
`endif

        // Continuous request stream: each clear accepted, 4 drops between
        p0 = pulses;
        wait_ready(ok);
        RW_INPUT = 1'b0; RS_INPUT = 1'b0; DATA_INPUT = 8'h01;
        for (int b = 0; b < 80; b++) begin
            exp_q.push_back({1'b0, 8'h01});
            @(posedge CLK);
            if (b < 79) wait_ready(ok);
        end
        #1;
        RW_INPUT = 1'b1; RS_INPUT = 1'b1; DATA_INPUT = 8'h02;
        wait_ready(ok);
        chk("stream80_pulses", pulses - p0, 32'd80);
`ifdef LCD_DROP_CNT_EN
        chk("drop_cnt_sat", {24'd0, DROP_CNT}, 32'hFF);
`endif

        // Reset while LCD_E is high
        wait_ready(ok);
        RW_INPUT = 1'b0; RS_INPUT = 1'b1; DATA_INPUT = 8'h5A;
        exp_q.push_back({1'b1, 8'h5A});
        @(posedge CLK);
        #1;
        RW_INPUT = 1'b1; RS_INPUT = 1'b1; DATA_INPUT = 8'h02;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (LCD_E) begin ok = 1'b1; break; end
        end
        chk("strobe_seen_before_reset", {31'd0, ok}, 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset_e", {30'd0, LCD_E, INIT_DONE}, 32'd0);
        chk("async_reset_ready", {31'd0, READY}, 32'd0);
        repeat (2) @(negedge CLK);
        push_init();
        RESET = 1'b0;
        check_init_trace();
`ifdef LCD_DROP_CNT_EN
        chk("drop_cnt_after_reset", {24'd0, DROP_CNT}, 32'd0);
`endif

        // Normal operation after the rerun
        send_byte(1'b1, 8'h7E, lat, s_rs, s_data, s_e0, s_e1);
        chk("post_reset_latency", lat, 32'd4);
        repeat (3) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
